safety_eoc_monitor: RTL and testbench
=====================================

Name: safety_eoc_monitor

Overview:
- Synthesizable end-of-computation monitor for the safety island, generalised from single-core status polling to NumHarts channels.
- Each hart reports `{done, exit_code}` through a register slave port.
- The block aggregates the reports, runs an optional timeout watchdog, and drives summary EOC/fail outputs plus a one-cycle interrupt.
- Off-chip JTAG polling of a single summary word replaces per-core polling.

Parameters:
- NumHarts, 4, number of monitored harts (1..16).
- AddrWidth, 8, register offset width in bytes.
- CntWidth, 32, timeout counter width.
- DefaultTimeout, 32'hFFFF_FFFF, reset value of the TIMEOUT register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  register request.
- we_i  in  1  write enable.
- addr_i  in  AddrWidth  byte offset, word aligned.
- wdata_i  in  32  write data.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  access error.
- eoc_o  out  1  computation ended (all done or timeout).
- fail_o  out  1  any nonzero exit code, or timeout.
- irq_o  out  1  one-cycle pulse on entry to DONE or TIMEOUT.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; slots cleared; CTRL=0; TIMEOUT=DefaultTimeout.
- Register map:
  - STATUS_h at 4*h, h<NumHarts, RW:
    - Write with wdata[31]=1 latches done=1 and code=wdata[30:0].
    - Write with wdata[31]=0 is ignored.
    - Once done=1 the slot is sticky; further writes are ignored and do not raise an error.
    - Read returns `{done, code}`.
  - CTRL at 0x40, RW:
    - bit0 tmo_en.
    - bit1 clear, write-one, self-clearing, reads 0.
  - TIMEOUT at 0x44, RW.
  - SUMMARY at 0x48, RO:
    - [31] all_done.
    - [30] timeout.
    - [29] fail.
    - [NumHarts-1:0] done mask.
    - Other bits 0.
  - COUNT at 0x4C, RO: current counter value.
- Handshake:
  - gnt_o = req_i, combinational.
  - rvalid_o=1 exactly one cycle after each granted request.
  - rdata_o is registered alongside it; rdata_o=0 on writes.
  - err_o=1 with rdata_o=0 for unmapped offsets, misaligned addr_i[1:0]!=0, and writes to SUMMARY/COUNT. Erroneous writes have no effect.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE -> RUN: on the first latched done bit, or on a write setting tmo_en=1.
  - RUN: counter increments each cycle while tmo_en=1 and saturates at all-ones.
    - RUN -> DONE when all NumHarts done bits are 1.
    - RUN -> TIMEOUT when tmo_en=1 and counter >= TIMEOUT.
    - If both conditions hold in the same cycle, DONE wins.
  - DONE/TIMEOUT: terminal. STATUS writes are ignored and the counter freezes.
  - Clear, from any state:
    - Zeroes slots and counter in the following cycle.
    - Next state is RUN if tmo_en remains 1, otherwise IDLE.
    - A clear takes priority over a same-cycle STATUS write or a same-cycle termination.
- Outputs:
  - eoc_o = state in {DONE, TIMEOUT}, registered.
  - fail_o = eoc_o && (timeout || any code!=0).
  - irq_o is high for exactly one cycle on the state-entry cycle.
- Ordering: a STATUS write completing the done mask in cycle t gives state DONE and eoc_o=1 at t+1.
- TIMEOUT=0 with tmo_en=1 enters TIMEOUT one cycle after RUN is entered, unless all harts are already done.
- Reset asserted mid-operation returns every register to its reset value immediately.

Decomposition:
- safety_eoc_monitor_pkg holds:
  - Register offset localparams: STATUS_BASE, CTRL_OFFSET, TIMEOUT_OFFSET, SUMMARY_OFFSET, COUNT_OFFSET.
  - SUMMARY bit indices.
  - The state enum typedef `eoc_state_e`.
  - A `status_t` struct `{done, code[30:0]}`.
- One sub-module, safety_eoc_slot: per-hart sticky latch with write/clear inputs and `status_t` output, instantiated NumHarts times.

Test Plan:
- Write STATUS_0..3 = 0x8000_0000 in sequence, tmo_en=0 -> state DONE after the 4th write, eoc_o=1, fail_o=0, irq_o one pulse, SUMMARY reads 0x8000_000F.
- Hart 2 writes 0x8000_0005, others write 0x8000_0000 -> eoc_o=1, fail_o=1, STATUS_2 reads 0x8000_0005, SUMMARY[29]=1.
- TIMEOUT=100, tmo_en=1, only hart 0 done -> TIMEOUT state after 100 counted cycles, SUMMARY=0x6000_0001, COUNT frozen at 100.
- Last STATUS write lands in the same cycle the counter reaches TIMEOUT -> DONE entered, SUMMARY[30]=0, fail_o=0.
- Second write 0x8000_0007 to an already-done STATUS_1 -> still reads its first value. Read of 0x50 -> err_o=1, rdata_o=0, rvalid_o one cycle later. Write to SUMMARY -> err_o=1, no state change.
- After DONE, write CTRL=0x2 -> slots and COUNT read 0, state IDLE, eoc_o=0. Assert rst_ni low mid-RUN -> all outputs 0 asynchronously, TIMEOUT reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/safety_eoc_monitor_pkg.sv
// Shared register map, summary bit positions, FSM state and per-hart status
// record for the end-of-computation monitor.
package safety_eoc_monitor_pkg;

   localparam int unsigned STATUS_BASE    = 'h00;
   localparam int unsigned CTRL_OFFSET    = 'h40;
   localparam int unsigned TIMEOUT_OFFSET = 'h44;
   localparam int unsigned SUMMARY_OFFSET = 'h48;
   localparam int unsigned COUNT_OFFSET   = 'h4C;

   localparam int unsigned SUM_ALL_DONE_BIT = 31;
   localparam int unsigned SUM_TIMEOUT_BIT  = 30;
   localparam int unsigned SUM_FAIL_BIT     = 29;

   localparam int unsigned CTRL_TMO_EN_BIT = 0;
   localparam int unsigned CTRL_CLEAR_BIT  = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } eoc_state_e;

   typedef struct packed {
      logic        done;
      logic [30:0] code;
   } status_t;

endpackage

// File: rtl/safety_eoc_slot.sv
// Per-hart sticky status latch: the first accepted report is held until a
// clear or reset.
module safety_eoc_slot
   import safety_eoc_monitor_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_i,
   input  logic        clr_i,
   input  logic [30:0] code_i,
   output status_t     status_o
);

   status_t status_q, status_d;

   always_comb begin
      status_d = status_q;
      if (clr_i) begin
         status_d = '0;
      end else if (wr_i && !status_q.done) begin
         status_d.done = 1'b1;
         status_d.code = code_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) status_q <= '0;
      else         status_q <= status_d;
   end

   assign status_o = status_q;

endmodule

// File: rtl/safety_eoc_monitor.sv
// Aggregates per-hart completion reports behind a register port and raises
// summary EOC/fail status with an optional timeout watchdog.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | nothing reported, watchdog not armed
// ST_RUN     | at least one report or watchdog armed; counter runs if tmo_en
// ST_DONE    | every hart reported (terminal until clear)
// ST_TIMEOUT | watchdog expired before all harts reported (terminal)
module safety_eoc_monitor
   import safety_eoc_monitor_pkg::*;
#(
   parameter int unsigned NumHarts       = 4,
   parameter int unsigned AddrWidth      = 8,
   parameter int unsigned CntWidth       = 32,
   parameter logic [31:0] DefaultTimeout = 32'hFFFF_FFFF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [31:0]          wdata_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [31:0]          rdata_o,
   output logic                 err_o,
   output logic                 eoc_o,
   output logic                 fail_o,
   output logic                 irq_o
);

   localparam int unsigned CmpW = (CntWidth > 32) ? CntWidth : 32;

   eoc_state_e          state_q, state_d;
   logic                tmo_en_q, tmo_en_d;
   logic [31:0]         timeout_q, timeout_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic                rvalid_q, err_q, eoc_q, irq_q;
   logic                err_d, eoc_d, irq_d;
   logic [31:0]         rdata_q, rdata_d;

   status_t             slot [NumHarts];
   logic [NumHarts-1:0] sel_status, slot_wr, done_vec, done_next;
   status_t             rd_status;
   logic                any_code, sel_ctrl, sel_tmo, sel_sum, sel_cnt;
   logic                acc_err, wr_ok, clear, terminal, tmo_arm, expired;
   logic [31:0]         sum_word;

   for (genvar h = 0; h < NumHarts; h++) begin : g_slot
      safety_eoc_slot u_slot (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .wr_i     (slot_wr[h]),
         .clr_i    (clear),
         .code_i   (wdata_i[30:0]),
         .status_o (slot[h])
      );
   end

   assign gnt_o  = req_i;
   assign fail_o = eoc_q && ((state_q == ST_TIMEOUT) || any_code);

   always_comb begin
      sel_status = '0;
      done_vec   = '0;
      rd_status  = '0;
      any_code   = 1'b0;
      for (int h = 0; h < NumHarts; h++) begin
         sel_status[h] = (addr_i == AddrWidth'(STATUS_BASE + 4 * h));
         done_vec[h]   = slot[h].done;
         any_code      = any_code | (|slot[h].code);
         if (sel_status[h]) rd_status = slot[h];
      end
      sel_ctrl = (addr_i == AddrWidth'(CTRL_OFFSET));
      sel_tmo  = (addr_i == AddrWidth'(TIMEOUT_OFFSET));
      sel_sum  = (addr_i == AddrWidth'(SUMMARY_OFFSET));
      sel_cnt  = (addr_i == AddrWidth'(COUNT_OFFSET));
      // Exact offset matches also reject misaligned addresses.
      acc_err  = !((|sel_status) || sel_ctrl || sel_tmo || sel_sum || sel_cnt) ||
                 (we_i && (sel_sum || sel_cnt));
      wr_ok    = req_i && we_i && !acc_err;
      clear    = wr_ok && sel_ctrl && wdata_i[CTRL_CLEAR_BIT];
      terminal = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
      tmo_arm  = wr_ok && sel_ctrl && wdata_i[CTRL_TMO_EN_BIT];
      expired  = tmo_en_q && (CmpW'(count_q) >= CmpW'(timeout_q));

      for (int h = 0; h < NumHarts; h++) begin
         slot_wr[h] = wr_ok && sel_status[h] && wdata_i[31] && !terminal && !clear;
      end
      done_next = done_vec | slot_wr;

      tmo_en_d  = (wr_ok && sel_ctrl) ? wdata_i[CTRL_TMO_EN_BIT] : tmo_en_q;
      timeout_d = (wr_ok && sel_tmo) ? wdata_i : timeout_q;

      state_d = state_q;
      if (clear) begin
         state_d = tmo_en_d ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (&done_next)                state_d = ST_DONE;
               else if ((|slot_wr) || tmo_arm) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (&done_next)   state_d = ST_DONE;
               else if (expired) state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
         endcase
      end

      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if ((state_q == ST_RUN) && (state_d == ST_RUN) && tmo_en_q &&
                   (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end

      eoc_d = (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
      irq_d = eoc_d && (state_d != state_q);

      sum_word                   = '0;
      sum_word[NumHarts-1:0]     = done_vec;
      sum_word[SUM_ALL_DONE_BIT] = &done_vec;
      sum_word[SUM_TIMEOUT_BIT]  = (state_q == ST_TIMEOUT);
      sum_word[SUM_FAIL_BIT]     = fail_o;

      err_d   = req_i && acc_err;
      rdata_d = '0;
      if (req_i && !we_i && !acc_err) begin
         if (|sel_status)  rdata_d = rd_status;
         else if (sel_ctrl) rdata_d = {31'b0, tmo_en_q};
         else if (sel_tmo)  rdata_d = timeout_q;
         else if (sel_sum)  rdata_d = sum_word;
         else               rdata_d = 32'(count_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         tmo_en_q  <= 1'b0;
         timeout_q <= DefaultTimeout;
         count_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         eoc_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_en_q  <= tmo_en_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         rvalid_q  <= req_i;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         eoc_q     <= eoc_d;
         irq_q     <= irq_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign eoc_o    = eoc_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_safety_eoc_monitor.sv
// Randomized and directed bench for safety_eoc_monitor against a
// transaction-level reference model of the monitor's rules.
module tb_safety_eoc_monitor;

   localparam int NH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [7:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        gnt_o, rvalid_o, err_o, eoc_o, fail_o, irq_o;
   logic [31:0] rdata_o;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: end_kind 0 = still running/idle, 1 = all done, 2 = timed out
   bit          m_done [NH];
   logic [30:0] m_code [NH];
   bit          m_tmo_en, m_started, m_irq;
   int          m_end;
   logic [31:0] m_timeout, m_count;

   always #5 clk = ~clk;

   safety_eoc_monitor dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .err_o(err_o), .eoc_o(eoc_o), .fail_o(fail_o), .irq_o(irq_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   task automatic m_reset();
      for (int h = 0; h < NH; h++) begin
         m_done[h] = 0;
         m_code[h] = '0;
      end
      m_tmo_en = 0; m_started = 0; m_irq = 0; m_end = 0;
      m_timeout = 32'hFFFF_FFFF; m_count = 0;
   endtask

   function automatic bit m_all_done();
      for (int h = 0; h < NH; h++) if (!m_done[h]) return 0;
      return 1;
   endfunction

   function automatic bit m_fail();
      bit bad = (m_end == 2);
      for (int h = 0; h < NH; h++) if (m_code[h] != 0) bad = 1;
      return (m_end != 0) && bad;
   endfunction

   task automatic m_step(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] er, output logic ee);
      int  wi = int'(a) / 4;
      bit  alig = (a % 4) == 0;
      bit  is_st = alig && wi < NH;
      bit  is_ctrl = a == 8'h40, is_tmo = a == 8'h44, is_sum = a == 8'h48, is_cnt = a == 8'h4C;
      bit  latched = 0, armed = 0;
      bit  old_tmo = m_tmo_en, old_started = m_started;
      logic [31:0] old_cnt = m_count, old_timeout = m_timeout;
      ee = r && (!(is_st || is_ctrl || is_tmo || is_sum || is_cnt) || (w && (is_sum || is_cnt)));
      er = 0;
      if (r && !w && !ee) begin
         if (is_st)        er = {m_done[wi], m_code[wi]};
         else if (is_ctrl) er = {31'b0, m_tmo_en};
         else if (is_tmo)  er = m_timeout;
         else if (is_cnt)  er = m_count;
         else begin
            for (int h = 0; h < NH; h++) er[h] = m_done[h];
            er[31] = m_all_done();
            er[30] = (m_end == 2);
            er[29] = m_fail();
         end
      end
      m_irq = 0;
      if (r && w && !ee && is_ctrl && d[1]) begin
         for (int h = 0; h < NH; h++) begin
            m_done[h] = 0;
            m_code[h] = '0;
         end
         m_count = 0; m_end = 0;
         m_tmo_en = d[0]; m_started = d[0];
         return;
      end
      if (r && w && !ee) begin
         if (is_st && d[31] && m_end == 0 && !m_done[wi]) begin
            m_done[wi] = 1; m_code[wi] = d[30:0]; latched = 1;
         end
         if (is_ctrl) begin
            m_tmo_en = d[0]; armed = d[0];
         end
         if (is_tmo) m_timeout = d;
      end
      if (m_end == 0) begin
         if (m_all_done()) begin
            m_end = 1; m_irq = 1;
         end else if (old_started && old_tmo && old_cnt >= old_timeout) begin
            m_end = 2; m_irq = 1;
         end else if (old_started && old_tmo && old_cnt != 32'hFFFF_FFFF) begin
            m_count = old_cnt + 1;
         end
         if (!old_started && (latched || armed)) m_started = 1;
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic re);
      logic [31:0] er;
      logic        ee;
      @(negedge clk);
      req = r; we = w; addr = a; wdata = d;
      m_step(r, w, a, d, er, ee);
      #1 check("gnt", gnt_o, r);
      @(posedge clk);
      #1;
      check("rvalid", rvalid_o, r);
      if (r) begin
         check($sformatf("rdata@%02h", a), rdata_o, er);
         check($sformatf("err@%02h", a), err_o, ee);
      end
      check("eoc", eoc_o, m_end != 0);
      check("fail", fail_o, m_fail());
      check("irq", irq_o, m_irq);
      rd = rdata_o;
      re = err_o;
   endtask

   logic [31:0] rd;
   logic        re;

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cyc(1, 1, a, d, rd, re);
   endtask

   task automatic rdr(input logic [7:0] a);
      cyc(1, 0, a, 0, rd, re);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rd, re);
   endtask

   initial begin
      m_reset();
      #23;
      check("rst_eoc", eoc_o, 0);
      check("rst_rvalid", rvalid_o, 0);
      check("rst_irq", irq_o, 0);
      @(negedge clk) rst_n = 1'b1;

      rdr(8'h44); check("tmo_default", rd, 32'hFFFF_FFFF);
      rdr(8'h48); check("sum_reset", rd, 32'h0);

      // all harts report success
      for (int h = 0; h < NH; h++) wr(8'(4 * h), 32'h8000_0000);
      check("done_eoc", eoc_o, 1);
      check("done_irq", irq_o, 1);
      rdr(8'h48); check("done_sum", rd, 32'h8000_000F);
      check("irq_single", irq_o, 0);

      // clear back to idle
      wr(8'h40, 32'h2);
      check("clr_eoc", eoc_o, 0);
      rdr(8'h00); check("clr_slot", rd, 32'h0);
      rdr(8'h4C); check("clr_cnt", rd, 32'h0);

      // one hart reports a failure code
      for (int h = 0; h < NH; h++) wr(8'(4 * h), (h == 2) ? 32'h8000_0005 : 32'h8000_0000);
      check("code_fail", fail_o, 1);
      rdr(8'h08); check("code_st2", rd, 32'h8000_0005);
      rdr(8'h48); check("code_sum29", rd[29], 1);

      // watchdog expiry with one hart done
      wr(8'h40, 32'h2);
      wr(8'h44, 32'd100);
      wr(8'h40, 32'h1);
      wr(8'h00, 32'h8000_0000);
      for (int i = 0; i < 200 && !eoc_o; i++) idle(1);
      check("tmo_eoc", eoc_o, 1);
      rdr(8'h48); check("tmo_sum", rd, 32'h6000_0001);
      idle(3);
      rdr(8'h4C); check("tmo_cnt", rd, 32'd100);

      // last report lands exactly when the counter reaches TIMEOUT
      wr(8'h40, 32'h2);
      wr(8'h44, 32'd10);
      wr(8'h40, 32'h1);
      for (int h = 0; h < NH - 1; h++) wr(8'(4 * h), 32'h8000_0000);
      for (int i = 0; i < 50 && m_count != 10; i++) idle(1);
      check("race_cnt_model", m_count, 10);
      wr(8'(4 * (NH - 1)), 32'h8000_0000);
      rdr(8'h48); check("race_sum", rd, 32'h8000_000F);
      check("race_fail", fail_o, 0);

      // zero timeout expires one cycle after RUN entry
      wr(8'h40, 32'h2);
      wr(8'h44, 32'd0);
      wr(8'h40, 32'h1);
      idle(1);
      check("tmo0_eoc", eoc_o, 1);

      // sticky slot and error responses
      wr(8'h40, 32'h2);
      wr(8'h44, 32'hFFFF_FFFF);
      wr(8'h04, 32'h8000_0003);
      wr(8'h04, 32'h8000_0007);
      check("sticky_err", re, 0);
      rdr(8'h04); check("sticky_val", rd, 32'h8000_0003);
      rdr(8'h50); check("unmap_err", re, 1); check("unmap_data", rd, 0);
      rdr(8'h41); check("misalign_err", re, 1);
      wr(8'h48, 32'hFFFF_FFFF); check("ro_err", re, 1);
      rdr(8'h48); check("ro_nochange", rd, 32'h0000_0002);

      // asynchronous reset while counting
      wr(8'h40, 32'h1);
      idle(5);
      rdr(8'h4C);
      req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_rvalid", rvalid_o, 0);
      check("arst_rdata", rdata_o, 0);
      check("arst_eoc", eoc_o, 0);
      check("arst_irq", irq_o, 0);
      m_reset();
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      rdr(8'h44); check("arst_tmo", rd, 32'hFFFF_FFFF);
      rdr(8'h04); check("arst_slot", rd, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic        r, w;
         logic [7:0]  a;
         logic [31:0] d;
         int          s;
         r = ($urandom % 4) != 0;
         w = ($urandom % 2) != 0;
         s = $urandom % 10;
         if (s < 5)      a = 8'(4 * ($urandom % NH));
         else if (s < 9) a = 8'h40 + 8'(4 * ($urandom % 4));
         else            a = 8'($urandom);
         if (a < 8'(4 * NH))
            d = {1'(($urandom % 4) != 0), (($urandom % 8) == 0) ? 31'($urandom % 16) : 31'd0};
         else if (a == 8'h40) d = {30'b0, 1'(($urandom % 4) == 0), 1'($urandom % 2)};
         else if (a == 8'h44) d = $urandom % 48;
         else                 d = $urandom;
         cyc(r, w, a, d, rd, re);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
